// File: rtl/uart_pkg.sv
// Shared types and default sizes for the UART receive-side buffer.
package uart_pkg;

  localparam int DEFAULT_DEPTH         = 8;
  localparam int DEFAULT_TIMEOUT_TICKS = 40;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic {
    READY,
    HOLD
  } rts_state_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// 2^ADDR_W x 9 register array: synchronous write port, combinational read port.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  rx_entry_t         i_wrData,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output rx_entry_t         o_rdData
);

  rx_entry_t r_mem [2**ADDR_W];

  // Contents need no reset: the read side is masked until an entry is written.
  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through RX byte buffer with overrun flag and rts hysteresis.
// Define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout counter driven by tick.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int HIGH_WATER    = DEPTH - 2,
  parameter int LOW_WATER     = DEPTH / 2,
  parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_done,
  input  logic                       rx_err,
  input  logic                       pop,
  output logic [7:0]                 rd_data,
  output logic                       rd_err,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overrun,
  output logic                       rts,
  input  logic                       tick,
  output logic                       timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH_CNT = CW'(HIGH_WATER);
  localparam logic [CW-1:0] LOW_CNT  = CW'(LOW_WATER);

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_overrun;
  rts_state_t    r_rtsState;

  logic          w_push;
  logic          w_pushOk;
  logic          w_popOk;
  logic          w_empty;
  logic          w_full;
  logic [CW-1:0] w_countNext;
  rts_state_t    w_rtsNext;
  rx_entry_t     w_wrEntry;
  rx_entry_t     w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_push   = rx_done | rx_err;
  // A push into a full buffer still lands when a pop frees a slot on the same edge.
  assign w_popOk  = pop & ~w_empty & ~clear;
  assign w_pushOk = w_push & (~w_full | w_popOk) & ~clear;

  assign w_wrEntry.err  = rx_err;
  assign w_wrEntry.data = rx_data;

  assign w_countNext = clear ? '0 : (r_count + CW'(w_pushOk) - CW'(w_popOk));

  uart_rx_fifo_mem #(
    .ADDR_W (AW)
  ) u_mem (
    .clk      (clk),
    .i_wrEn   (w_pushOk),
    .i_wrAddr (r_wrPtr),
    .i_wrData (w_wrEntry),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_popOk)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= w_countNext;
      if (w_push && w_full && !w_popOk) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rtsState <= READY;
    else       r_rtsState <= w_rtsNext;
  end

  // Hysteresis is judged on the post-edge count so rts moves with count.
  always_comb begin
    w_rtsNext = r_rtsState;
    if (clear) begin
      w_rtsNext = READY;
    end else begin
      case (r_rtsState)
        READY:   if (w_countNext >= HIGH_CNT) w_rtsNext = HOLD;
        HOLD:    if (w_countNext <= LOW_CNT)  w_rtsNext = READY;
        default: w_rtsNext = READY;
      endcase
    end
  end

  assign rd_data = w_empty ? 8'h00 : w_head.data;
  assign rd_err  = w_empty ? 1'b0  : w_head.err;
  assign empty   = w_empty;
  assign full    = w_full;
  assign count   = r_count;
  assign overrun = r_overrun;
  assign rts     = (r_rtsState == READY);

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

  logic [TW-1:0] r_idleCnt;
  logic          r_timeout;

  // Counts ticks of inactivity while data sits unread; the counter parks once it fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idleCnt <= '0;
      r_timeout <= 1'b0;
    end else if (clear) begin
      r_idleCnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_popOk) r_timeout <= 1'b0;
      if (w_empty || w_push || w_popOk) begin
        r_idleCnt <= '0;
      end else if (tick) begin
        if (r_idleCnt == TO_LAST) r_timeout <= 1'b1;
        else                      r_idleCnt <= r_idleCnt + 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  logic [1:0] w_unusedTimeout;
  assign w_unusedTimeout = {tick, TIMEOUT_TICKS[0]};
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model plus literal spot checks.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int HIGH_WATER = 6;
  localparam int LOW_WATER = 4;
  localparam int TIMEOUT_TICKS = 40;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam logic TIMEOUT_BUILT = 1'b1;
`else
  localparam logic TIMEOUT_BUILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_err = 1'b0;
  logic       pop = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overrun;
  logic       rts;
  logic       timeout;

  int checks = 0;
  int errors = 0;
  bit compareOn = 1'b0;

  uart_rx_fifo dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rx_err  (rx_err),
    .pop     (pop),
    .rd_data (rd_data),
    .rd_err  (rd_err),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .overrun (overrun),
    .rts     (rts),
    .tick    (tick),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: the buffer is a plain queue, flags follow directly from its size.
  logic [8:0] mq[$];
  logic mOverrun = 1'b0;
  logic mRts = 1'b1;
  logic mTimeout = 1'b0;
  int   mIdle = 0;

  always @(posedge clk or posedge reset) begin
    bit doPush, doPop, wasEmpty, wasFull;
    if (reset || clear) begin
      mq.delete();
      mOverrun = 1'b0;
      mRts = 1'b1;
      mTimeout = 1'b0;
      mIdle = 0;
    end else begin
      doPush = rx_done || rx_err;
      wasEmpty = (mq.size() == 0);
      wasFull = (mq.size() == DEPTH);
      doPop = pop && !wasEmpty;
      if (doPush && wasFull && !doPop) mOverrun = 1'b1;
      if (doPop) void'(mq.pop_front());
      if (doPush && (!wasFull || doPop)) mq.push_back({rx_err, rx_data});
      if (mq.size() >= HIGH_WATER) mRts = 1'b0;
      else if (mq.size() <= LOW_WATER) mRts = 1'b1;
      if (doPop) mTimeout = 1'b0;
      if (wasEmpty || doPush || doPop) mIdle = 0;
      else if (tick) mIdle++;
      if (mIdle >= TIMEOUT_TICKS && TIMEOUT_BUILT) mTimeout = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compareOn && !reset) begin
      checkOutput("cmpCount", 32'(count), 32'(mq.size()));
      checkOutput("cmpEmpty", 32'(empty), 32'(mq.size() == 0));
      checkOutput("cmpFull", 32'(full), 32'(mq.size() == DEPTH));
      checkOutput("cmpRdData", 32'(rd_data), (mq.size() == 0) ? 32'h0 : 32'(mq[0][7:0]));
      checkOutput("cmpRdErr", 32'(rd_err), (mq.size() == 0) ? 32'h0 : 32'(mq[0][8]));
      checkOutput("cmpOverrun", 32'(overrun), 32'(mOverrun));
      checkOutput("cmpRts", 32'(rts), 32'(mRts));
      checkOutput("cmpTimeout", 32'(timeout), 32'(mTimeout));
    end
  end

  task automatic applyStimulus(input logic done, input logic err, input logic [7:0] data,
                               input logic popIn, input logic clr, input logic tk);
    @(negedge clk);
    #1;
    rx_done = done;
    rx_err  = err;
    rx_data = data;
    pop     = popIn;
    clear   = clr;
    tick    = tk;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_err  = 1'b0;
    rx_data = 8'h00;
    pop     = 1'b0;
    clear   = 1'b0;
    tick    = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popByte();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] order [8];
    #2;
    checkOutput("resetCount", 32'(count), 32'd0);
    checkOutput("resetEmpty", 32'(empty), 32'd1);
    checkOutput("resetFull", 32'(full), 32'd0);
    checkOutput("resetOverrun", 32'(overrun), 32'd0);
    checkOutput("resetRts", 32'(rts), 32'd1);
    checkOutput("resetTimeout", 32'(timeout), 32'd0);
    checkOutput("resetRdData", 32'(rd_data), 32'd0);
    #15;
    reset = 1'b0;
    compareOn = 1'b1;

    pushByte(8'h41);
    pushByte(8'h42);
    pushByte(8'h43);
    checkOutput("basicCount", 32'(count), 32'd3);
    checkOutput("basicHead", 32'(rd_data), 32'h41);
    checkOutput("basicHeadErr", 32'(rd_err), 32'd0);
    popByte();
    checkOutput("basicPop1", 32'(rd_data), 32'h42);
    popByte();
    checkOutput("basicPop2", 32'(rd_data), 32'h43);
    popByte();
    checkOutput("basicEmpty", 32'(empty), 32'd1);
    checkOutput("basicEmptyData", 32'(rd_data), 32'd0);

    for (int i = 0; i < 8; i++) begin
      pushByte(8'h10 + 8'(i));
      if (i == 5) checkOutput("fillRtsDrop", 32'(rts), 32'd0);
    end
    checkOutput("fillFull", 32'(full), 32'd1);
    checkOutput("fillOverrunPre", 32'(overrun), 32'd0);
    pushByte(8'hEE);
    checkOutput("overrunSet", 32'(overrun), 32'd1);
    checkOutput("overrunCount", 32'(count), 32'd8);
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    checkOutput("fullPushPopCount", 32'(count), 32'd8);
    order = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    for (int i = 0; i < 8; i++) begin
      checkOutput("drainOrder", 32'(rd_data), 32'(order[i]));
      popByte();
    end
    checkOutput("drainEmpty", 32'(empty), 32'd1);
    checkOutput("overrunSticky", 32'(overrun), 32'd1);

    applyStimulus(1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0);
    checkOutput("bothCount", 32'(count), 32'd1);
    checkOutput("bothData", 32'(rd_data), 32'h7F);
    checkOutput("bothErr", 32'(rd_err), 32'd1);
    popByte();

    for (int i = 0; i < 5; i++) pushByte(8'h20 + 8'(i));
    checkOutput("rtsAt5", 32'(rts), 32'd1);
    pushByte(8'h25);
    checkOutput("rtsAt6", 32'(rts), 32'd0);
    popByte();
    checkOutput("rtsAt5Hold", 32'(rts), 32'd0);
    popByte();
    checkOutput("rtsAt4", 32'(rts), 32'd1);
    popByte();
    checkOutput("preClearCount", 32'(count), 32'd3);

    applyStimulus(1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0);
    checkOutput("clearCount", 32'(count), 32'd0);
    checkOutput("clearOverrun", 32'(overrun), 32'd0);
    checkOutput("clearRts", 32'(rts), 32'd1);
    checkOutput("clearEmpty", 32'(empty), 32'd1);

    pushByte(8'h31);
    pushByte(8'h32);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncCount", 32'(count), 32'd0);
    checkOutput("asyncEmpty", 32'(empty), 32'd1);
    checkOutput("asyncRdData", 32'(rd_data), 32'd0);
    checkOutput("asyncRts", 32'(rts), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;

    pushByte(8'h99);
    for (int i = 0; i < TIMEOUT_TICKS - 1; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("timeoutEarly", 32'(timeout), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("timeoutFire", 32'(timeout), 32'(TIMEOUT_BUILT));
    popByte();
    checkOutput("timeoutPopClr", 32'(timeout), 32'd0);

    popByte();
    checkOutput("popEmptyCount", 32'(count), 32'd0);
    checkOutput("popEmptyOverrun", 32'(overrun), 32'd0);

    @(negedge clk);
    compareOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
